// File: rtl/pixel_source_sched.sv
// pixel_source_sched -- raster scheduler for the HDMI pixel path.
//
// Scans h_count/v_count over H_TOTAL x V_TOTAL clocks. During active video it
// pops frame-buffer pixels from the DDR-read FIFO. If the FIFO head is not
// valid when a pixel is needed, it shows the background pattern for the rest
// of that frame, sets a sticky underrun flag, and resumes streaming at the
// next frame origin.
//
// Optional build macro: PIXEL_SOURCE_SCHED_UNDERRUN_CNT_EN
//   When defined, adds underrun_cnt, a saturating count of frames that
//   contained at least one underrun.
//
// Ports:
//   clk          in   pixel clock
//   rst          in   synchronous reset, active-low
//   en           in   scan enable; low returns the scheduler to IDLE
//   h_count      out  registered x coordinate, to background generator
//   v_count      out  registered y coordinate, to background generator
//   bg_data      in   background pixel for the current h_count/v_count
//   fb_data      in   frame-buffer pixel (FIFO head)
//   fb_valid     in   FIFO head valid
//   fb_ready     out  pop FIFO head this cycle (combinational)
//   frame_start  out  one-cycle pulse while the counters read (0,0)
//   pix_data     out  pixel to encoder, one cycle behind the counters
//   pix_de       out  data enable, aligned with pix_data
//   underrun     out  sticky underrun flag
//   underrun_clr in   clears underrun (a simultaneous set wins)
//   underrun_cnt out  frames with an underrun (optional build only)

module pixel_source_sched #(
   parameter int H_ACTIVE = 320,
   parameter int H_TOTAL  = 400,
   parameter int V_ACTIVE = 240,
   parameter int V_TOTAL  = 262
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic [9:0]  h_count,
   output logic [8:0]  v_count,
   input  logic [15:0] bg_data,
   input  logic [15:0] fb_data,
   input  logic        fb_valid,
   output logic        fb_ready,
   output logic        frame_start,
   output logic [15:0] pix_data,
   output logic        pix_de,
   output logic        underrun,
   input  logic        underrun_clr
`ifdef PIXEL_SOURCE_SCHED_UNDERRUN_CNT_EN
   ,
   output logic [15:0] underrun_cnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_STREAM   = 2'd1,
      S_FALLBACK = 2'd2
   } state_t;

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
   localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
   localparam logic [8:0] V_ACT  = 9'(V_ACTIVE);

   state_t      state_q, state_d;
   logic [9:0]  h_q, h_d;
   logic [8:0]  v_q, v_d;
   logic [15:0] pix_data_q, pix_data_d;
   logic        pix_de_q, pix_de_d;
   logic        frame_start_q, frame_start_d;
   logic        underrun_q, underrun_d;
   logic        active;
   logic        h_wrap;
   logic        v_wrap;
   logic        ur_set;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      state_d    = state_q;
      h_d        = h_q;
      v_d        = v_q;
      pix_data_d = '0;
      pix_de_d   = 1'b0;
      ur_set     = 1'b0;

      active   = (h_q < H_ACT) && (v_q < V_ACT);
      fb_ready = active && (state_q == S_STREAM);
      h_wrap   = (h_q == H_LAST);
      v_wrap   = (v_q == V_LAST);

      case (state_q)
         S_IDLE: begin
            h_d = '0;
            v_d = '0;
            if (en) state_d = S_STREAM;
         end
         default: begin
            h_d = h_wrap ? 10'd0 : h_q + 10'd1;
            v_d = h_wrap ? (v_wrap ? 9'd0 : v_q + 9'd1) : v_q;
            if (active) begin
               pix_de_d   = 1'b1;
               pix_data_d = (state_q == S_STREAM && fb_valid) ? fb_data : bg_data;
               if (state_q == S_STREAM && !fb_valid) begin
                  // Background for the rest of this frame; no mid-frame recovery.
                  ur_set  = 1'b1;
                  state_d = S_FALLBACK;
               end
            end
            // Leave fallback exactly as the scan wraps to the frame origin.
            if (state_q == S_FALLBACK && h_wrap && v_wrap) state_d = S_STREAM;
         end
      endcase

      // Dropping en abandons the frame regardless of state.
      if (!en) begin
         state_d    = S_IDLE;
         h_d        = '0;
         v_d        = '0;
         pix_data_d = '0;
         pix_de_d   = 1'b0;
         ur_set     = 1'b0;
      end

      underrun_d    = ur_set | (underrun_q & ~underrun_clr);
      frame_start_d = (state_d != S_IDLE) && (h_d == 10'd0) && (v_d == 9'd0);
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples the pre-edge values computed above.
      if (!rst) begin
         state_q       <= S_IDLE;
         h_q           <= '0;
         v_q           <= '0;
         pix_data_q    <= '0;
         pix_de_q      <= 1'b0;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         h_q           <= h_d;
         v_q           <= v_d;
         pix_data_q    <= pix_data_d;
         pix_de_q      <= pix_de_d;
         frame_start_q <= frame_start_d;
         underrun_q    <= underrun_d;
      end
   end

`ifdef PIXEL_SOURCE_SCHED_UNDERRUN_CNT_EN
   logic [15:0] cnt_q, cnt_d;

   // Only one STREAM->FALLBACK transition can happen per frame, so counting
   // the set events counts frames. A set alongside a clear restarts at 1.
   always_comb begin
      cnt_d = cnt_q;
      if (ur_set)            cnt_d = underrun_clr ? 16'd1 : ((cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1);
      else if (underrun_clr) cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign underrun_cnt = cnt_q;
`endif

   assign h_count     = h_q;
   assign v_count     = v_q;
   assign pix_data    = pix_data_q;
   assign pix_de      = pix_de_q;
   assign frame_start = frame_start_q;
   assign underrun    = underrun_q;

endmodule

// File: tb/tb_pixel_source_sched.sv
// Self-checking bench for pixel_source_sched using a reduced raster so that
// several complete frames fit in a short run. A frame-position model predicts
// the outputs; the stimulus pushes its prediction into a queue and an
// independent monitor pops and compares after each clock edge.

module tb_pixel_source_sched;

   localparam int HA = 14;
   localparam int HT = 20;
   localparam int VA = 7;
   localparam int VT = 10;
   localparam int FT = HT * VT;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic [9:0]  h_count;
   logic [8:0]  v_count;
   logic [15:0] bg_data;
   logic [15:0] fb_data = '0;
   logic        fb_valid = 1'b0;
   logic        fb_ready;
   logic        frame_start;
   logic [15:0] pix_data;
   logic        pix_de;
   logic        underrun;
   logic        underrun_clr = 1'b0;
`ifdef PIXEL_SOURCE_SCHED_UNDERRUN_CNT_EN
   logic [15:0] underrun_cnt;
`endif

   always #5 clk = ~clk;

   // Background generator: a fixed function of the coordinates.
   function automatic logic [15:0] bg_fn(input int h, input int v);
      return 16'((32'hA000) ^ (v * 64) ^ h);
   endfunction

   assign bg_data = bg_fn(int'(h_count), int'(v_count));

   pixel_source_sched #(.H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .h_count      (h_count),
      .v_count      (v_count),
      .bg_data      (bg_data),
      .fb_data      (fb_data),
      .fb_valid     (fb_valid),
      .fb_ready     (fb_ready),
      .frame_start  (frame_start),
      .pix_data     (pix_data),
      .pix_de       (pix_de),
      .underrun     (underrun),
      .underrun_clr (underrun_clr)
`ifdef PIXEL_SOURCE_SCHED_UNDERRUN_CNT_EN
      ,
      .underrun_cnt (underrun_cnt)
`endif
   );

   // ---------------- reference model ----------------
   // m_pos is the scan position within the frame (0..FT-1); m_bad marks a
   // frame that has already lost its FIFO stream.
   int          m_pos  = 0;
   bit          m_scan = 1'b0;
   bit          m_bad  = 1'b0;
   bit          m_und  = 1'b0;
   int          m_cnt  = 0;
   logic [15:0] m_pix  = '0;
   bit          m_de   = 1'b0;

   typedef struct {
      int          h;
      int          v;
      bit          fs;
      bit          rdy;
      logic [15:0] pix;
      bit          de;
      bit          und;
      int          cnt;
   } exp_t;

   exp_t exp_q[$];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
      end
   endtask

   task automatic model_step(input bit r, input bit e, input bit fv, input logic [15:0] fd, input bit clr);
      int h = m_pos % HT;
      int v = m_pos / HT;
      bit act = (h < HA) && (v < VA);
      bit set = 1'b0;
      if (!r) begin
         m_pos = 0; m_scan = 0; m_bad = 0; m_und = 0; m_cnt = 0; m_pix = '0; m_de = 0;
         return;
      end
      if (!e) begin
         m_scan = 0; m_pos = 0; m_bad = 0; m_pix = '0; m_de = 0;
      end else if (!m_scan) begin
         m_scan = 1; m_pos = 0; m_bad = 0; m_pix = '0; m_de = 0;
      end else begin
         if (act) begin
            m_de  = 1;
            m_pix = (!m_bad && fv) ? fd : bg_fn(h, v);
            if (!m_bad && !fv) begin
               m_bad = 1;
               set   = 1;
            end
         end else begin
            m_de  = 0;
            m_pix = '0;
         end
         m_pos = (m_pos + 1) % FT;
         if (m_pos == 0) m_bad = 0;
      end
      m_und = set || (m_und && !clr);
      if (set)      m_cnt = clr ? 1 : ((m_cnt == 65535) ? 65535 : m_cnt + 1);
      else if (clr) m_cnt = 0;
   endtask

   // Drive one cycle of inputs (before the coming posedge) and queue the
   // outputs expected after that edge.
   task automatic cyc(input bit r, input bit e, input bit fv, input logic [15:0] fd, input bit clr);
      exp_t x;
      rst = r; en = e; fb_valid = fv; fb_data = fd; underrun_clr = clr;
      model_step(r, e, fv, fd, clr);
      x.h   = m_pos % HT;
      x.v   = m_pos / HT;
      x.fs  = m_scan && (m_pos == 0);
      x.rdy = m_scan && !m_bad && ((m_pos % HT) < HA) && ((m_pos / HT) < VA);
      x.pix = m_pix;
      x.de  = m_de;
      x.und = m_und;
      x.cnt = m_cnt;
      exp_q.push_back(x);
      @(negedge clk);
   endtask

   logic [15:0] fd_ctr = '0;

   task automatic stream(input int n);
      for (int i = 0; i < n; i++) begin
         cyc(1, 1, 1, fd_ctr, 0);
         fd_ctr++;
      end
   endtask

   // Stream clean pixels until the counters read (h,v); bounded by two frames.
   task automatic go_to(input int h, input int v);
      int n = 0;
      while (m_pos != v * HT + h && n < 2 * FT) begin
         cyc(1, 1, 1, fd_ctr, 0);
         fd_ctr++;
         n++;
      end
      check("go_to_position", 32'(m_pos), 32'(v * HT + h));
   endtask

   // ---------------- monitor ----------------
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            check("h_count", 32'(h_count), 32'(x.h));
            check("v_count", 32'(v_count), 32'(x.v));
            check("frame_start", 32'(frame_start), 32'(x.fs));
            check("fb_ready", 32'(fb_ready), 32'(x.rdy));
            check("pix_de", 32'(pix_de), 32'(x.de));
            check("pix_data", 32'(pix_data), 32'(x.pix));
            check("underrun", 32'(underrun), 32'(x.und));
`ifdef PIXEL_SOURCE_SCHED_UNDERRUN_CNT_EN
            check("underrun_cnt", 32'(underrun_cnt), 32'(x.cnt));
`endif
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      // Reset with en high, then idle.
      repeat (3) cyc(0, 1, 1, 16'h1234, 0);
      repeat (2) cyc(1, 0, 1, 16'h1234, 0);

      // Clean streaming for two full frames plus a little.
      stream(2 * FT + 5);

      // Single-cycle dropout mid-frame; fallback until the next frame.
      go_to(5, 3);
      cyc(1, 1, 0, fd_ctr, 0);
      stream(FT);

      // Clear coincident with a new underrun: set wins. Then clear alone.
      go_to(2, 1);
      cyc(1, 1, 0, fd_ctr, 1);
      cyc(1, 1, 1, fd_ctr, 1);
      stream(FT);

      // Drop en mid-frame, idle, re-enable.
      go_to(8, 4);
      cyc(1, 0, 1, fd_ctr, 0);
      cyc(1, 0, 1, fd_ctr, 0);
      stream(FT + 3);

      // Reset while in fallback.
      go_to(3, 2);
      cyc(1, 1, 0, fd_ctr, 0);
      stream(10);
      cyc(0, 1, 1, fd_ctr, 0);
      stream(3);

      // Three underrun frames, the second with two dropouts.
      for (int f = 0; f < 3; f++) begin
         go_to(1, 1);
         cyc(1, 1, 0, fd_ctr, 0);
         if (f == 1) begin
            go_to(6, 5);
            cyc(1, 1, 0, fd_ctr, 0);
         end
         go_to(0, 0);
      end
      stream(5);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 799) != 0), ($urandom_range(0, 399) != 0),
             ($urandom_range(0, 99) != 0), 16'($urandom),
             ($urandom_range(0, 39) == 0));
      end

      @(posedge clk);
      #2;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pixel_source_sched.md
Name: pixel_source_sched

Overview:
- Raster scheduler for the HDMI pixel path.
- Generates the h_count/v_count scan that drives the background generator.
- Pops frame-buffer pixels from the DDR-read FIFO during active video.
- Substitutes the background pattern on FIFO underrun and flags the fault.
- Sits between the DDR read path / background generator and the HDMI encoder.

Parameters:
H_ACTIVE, 320, active pixels per line
H_TOTAL, 400, clocks per line incl. blanking (max 1023)
V_ACTIVE, 240, active lines per frame
V_TOTAL, 262, lines per frame incl. blanking (max 511)

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous reset, active-low
en  in  1  scan enable
h_count  out  10  x coordinate, to background generator
v_count  out  9  y coordinate, to background generator
bg_data  in  16  background pixel for current h_count/v_count (combinational from generator)
fb_data  in  16  frame-buffer pixel (FIFO head)
fb_valid  in  1  FIFO head valid
fb_ready  out  1  pop FIFO head this cycle
frame_start  out  1  one-cycle pulse at frame origin; DDR reader restarts and flushes on it
pix_data  out  16  pixel to encoder
pix_de  out  1  data enable
underrun  out  1  sticky underrun flag
underrun_clr  in  1  clears underrun

Behaviour:
- Reset (rst=0 at clk edge) forces all registered outputs to 0 and state to IDLE:
  - h_count, v_count, pix_data, pix_de, frame_start, underrun all 0.
- States: IDLE, STREAM, FALLBACK.
- IDLE:
  - Counters held at 0; fb_ready=0; pix_de=0.
  - en=1 -> STREAM. First scanning cycle shows counters (0,0) with frame_start=1.
- Counters (while not IDLE):
  - h increments each clk; at H_TOTAL-1 wraps to 0 and v increments.
  - v wraps from V_TOTAL-1 to 0.
  - frame_start=1 exactly in cycles where registered counters read (0,0).
- en=0 in any state:
  - Next cycle: IDLE, counters 0, pix_de 0, pix_data 0.
  - underrun is preserved.
- active = (h_count<H_ACTIVE) && (v_count<V_ACTIVE), evaluated on the registered counters.
- fb_ready = active && state==STREAM (combinational).
- Pixel pipeline:
  - pix_data/pix_de are registered and lag the counters by exactly 1 cycle.
  - STREAM, active, fb_valid=1: pix_data<=fb_data; pix_de<=1; FIFO pops.
  - STREAM, active, fb_valid=0: pix_data<=bg_data; pix_de<=1; underrun<=1; state -> FALLBACK.
  - FALLBACK, active: pix_data<=bg_data; pix_de<=1; fb_ready=0.
  - Blanking, any state: pix_data<=0; pix_de<=0.
- FALLBACK -> STREAM on the cycle whose next counters are (0,0), so the next frame starts in STREAM.
- Never pops outside active video. An underrun never recovers mid-frame.
- underrun_clr=1 clears underrun next cycle; a simultaneous set wins.
- Mid-frame reset or en drop abandons the frame; no partial-frame state survives.

Optional Feature:
- Macro: PIXEL_SOURCE_SCHED_UNDERRUN_CNT_EN.
- Defined:
  - Adds output underrun_cnt[15:0]: count of frames containing at least one underrun.
  - Increments once per frame at the STREAM->FALLBACK transition; saturates at 16'hFFFF.
  - Cleared by reset and by underrun_clr (a simultaneous increment wins, giving 1).
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then en=1, fb_valid=1 constant, fb_data=counter pattern:
  - frame_start high at cycle 0 and again exactly 400*262=104800 cycles later.
  - pix_de high for 320 cycles per line on lines 0..239, delayed 1 cycle from counters.
  - 76800 pops per frame; underrun stays 0.
- Wrap check: h_count 399->0 with v_count 5->6; at (399,261) next counters are (0,0).
- fb_valid dropped for 1 cycle at (100,50):
  - pix_data equals bg_data of (100,50) one cycle later; underrun=1.
  - fb_ready=0 for the rest of the frame; STREAM and pops resume at the next (0,0).
- underrun_clr asserted during an underrun event -> underrun remains 1. Asserted alone -> 0 next cycle.
- en dropped at (200,100) -> next cycle counters (0,0), pix_de=0, fb_ready=0.
  - Re-enable -> frame_start on the first cycle.
- rst=0 mid-frame in FALLBACK -> all outputs 0, underrun 0, IDLE.
  - With the macro: underrun_cnt=0. Three underrun frames, one with two dropouts -> count 3.
